// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package if_pkg;

    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] WORD_ALIGN_MASK   = 32'hFFFF_FFFC;
    localparam logic [INSTR_W-1:0] PC_STEP           = 32'd4;

    // FETCH issues the request, WAIT awaits the response, HOLD parks a word ID cannot take yet.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats stall-hold, otherwise the slot drains to a bubble.
module if_id_reg
    import if_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               load_i,
    input  logic               stall_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [INSTR_W-1:0] pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [INSTR_W-1:0] pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end else if (!stall_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, hold buffer and redirect handling.
// Define IF_PERF_CNT_EN to add the fetch_cnt / stall_cnt performance counter outputs.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_id,
    input  logic               redirect_valid,
    input  logic [INSTR_W-1:0] redirect_pc,
    output logic [INSTR_W-1:0] instruction_if_id,
    output logic [INSTR_W-1:0] pc_if_id,
    output logic               valid_if_id
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic [INSTR_W-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic               drop_q, drop_d;

    logic               load;
    logic [INSTR_W-1:0] load_instr;
    logic [INSTR_W-1:0] load_pc;
    logic [INSTR_W-1:0] pc_plus4;
    logic               slot_free;

    assign pc_plus4  = pc_q + PC_STEP;
    assign slot_free = !valid_if_id || !stall_id;

    // Request is gated by rst_n so it stays low while reset is held, even though the state already reads FETCH.
    assign imem_req  = rst_n && (state_q == FETCH);
    assign imem_addr = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        drop_d     = drop_q;
        load       = 1'b0;
        load_instr = hold_q;
        load_pc    = pc_q;

        case (state_q)
            FETCH: begin
                if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = FETCH;
                    end else if (slot_free) begin
                        load       = 1'b1;
                        load_instr = imem_rdata;
                        load_pc    = pc_plus4;
                        pc_d       = pc_plus4;
                        state_d    = FETCH;
                    end else begin
                        hold_d  = imem_rdata;
                        pc_d    = pc_plus4;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // pc_q was already advanced on capture, so it equals PC+4 of the parked word.
                if (!stall_id) begin
                    load       = 1'b1;
                    load_instr = hold_q;
                    load_pc    = pc_q;
                    state_d    = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // A redirect wins over everything; a response still in flight is marked to be dropped.
        if (redirect_valid) begin
            pc_d   = word_align(redirect_pc);
            hold_d = NOP_INSTR;
            load   = 1'b0;
            case (state_q)
                FETCH: begin
                    if (imem_gnt) begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_d = FETCH;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = WAIT;
                        drop_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            hold_q  <= NOP_INSTR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
            drop_q  <= drop_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (redirect_valid),
        .load_i  (load),
        .stall_i (stall_id),
        .instr_i (load_instr),
        .pc_i    (load_pc),
        .instr_o (instruction_if_id),
        .pc_o    (pc_if_id),
        .valid_o (valid_if_id)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (load) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (valid_if_id && stall_id) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios then randomized memory/stall/redirect traffic.
module tb_if_fetch_stage;
    import if_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall_id = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instruction_if_id;
    logic [31:0] pc_if_id;
    logic        valid_if_id;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_gnt          (imem_gnt),
        .imem_rvalid       (imem_rvalid),
        .imem_rdata        (imem_rdata),
        .stall_id          (stall_id),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .instruction_if_id (instruction_if_id),
        .pc_if_id          (pc_if_id),
        .valid_if_id       (valid_if_id)
    );

    int checks = 0;
    int errors = 0;

    int gntPct = 100;
    int latLo  = 1;
    int latHi  = 1;

    bit          outstanding = 1'b0;
    int          latLeft = 0;
    logic [31:0] outAddr = '0;
    bit          prevPending = 1'b0;
    logic [31:0] prevAddr = '0;

    logic [31:0] expPc = RESET_PC;
    int          delivered = 0;
    int          grantCount = 0;
    logic [31:0] lastGrantAddr = '0;
    logic [31:0] grantAddrs[16];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the negedge, play the memory, drive inputs, then check the IF/ID stream after the edge.
    task automatic applyStimulus(input logic stallIn, input logic redirIn, input logic [31:0] redirPcIn);
        logic        preReq;
        logic        preValid;
        logic [31:0] preAddr;
        logic [31:0] preInstr;
        logic [31:0] prePc;
        logic        gntNow;
        logic        rvNow;
        logic [31:0] rdNow;

        preReq   = imem_req;
        preAddr  = imem_addr;
        preValid = valid_if_id;
        preInstr = instruction_if_id;
        prePc    = pc_if_id;

        if (preReq) begin
            checkOutput("addr_align", {30'd0, preAddr[1:0]}, 32'd0);
            checkOutput("req_while_busy", {31'd0, outstanding}, 32'd0);
        end
        if (prevPending) begin
            checkOutput("req_hold", {31'd0, preReq}, 32'd1);
            checkOutput("addr_hold", preAddr, prevAddr);
        end

        gntNow = preReq && ($urandom_range(99) < gntPct);
        rvNow  = 1'b0;
        rdNow  = $urandom;
        if (outstanding) begin
            if (latLeft == 0) begin
                rvNow = 1'b1;
                rdNow = memWord(outAddr);
            end else begin
                latLeft--;
            end
        end

        imem_gnt       = gntNow;
        imem_rvalid    = rvNow;
        imem_rdata     = rdNow;
        stall_id       = stallIn;
        redirect_valid = redirIn;
        redirect_pc    = redirPcIn;

        @(negedge clk);

        if (rvNow) outstanding = 1'b0;
        if (gntNow) begin
            outstanding = 1'b1;
            outAddr     = preAddr;
            latLeft     = int'($urandom_range(latHi, latLo)) - 1;
            if (grantCount < 16) grantAddrs[grantCount] = preAddr;
            grantCount++;
            lastGrantAddr = preAddr;
        end
        prevPending = preReq && !gntNow && !redirIn;
        prevAddr    = preAddr;

        if (redirIn) begin
            checkOutput("flush_valid", {31'd0, valid_if_id}, 32'd0);
            checkOutput("flush_instr", instruction_if_id, NOP);
            expPc = {redirPcIn[31:2], 2'b00};
        end else if (preValid && stallIn) begin
            checkOutput("stall_valid", {31'd0, valid_if_id}, 32'd1);
            checkOutput("stall_instr", instruction_if_id, preInstr);
            checkOutput("stall_pc", pc_if_id, prePc);
        end else if (valid_if_id) begin
            checkOutput("deliver_instr", instruction_if_id, memWord(expPc));
            checkOutput("deliver_pc", pc_if_id, expPc + 32'd4);
            expPc = expPc + 32'd4;
            delivered++;
        end else begin
            checkOutput("bubble_instr", instruction_if_id, NOP);
        end
    endtask

    initial begin
        int          gc0;
        int          d0;
        logic [31:0] pcR;
        bit          altExp[6];

        altExp = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_addr", imem_addr, RESET_PC);
        checkOutput("rst_instr", instruction_if_id, NOP);
        checkOutput("rst_pc", pc_if_id, 32'd0);
        checkOutput("rst_valid", {31'd0, valid_if_id}, 32'd0);
        rst_n = 1'b1;
        #1;

        // Back-to-back fetch with a 1-cycle memory: valid every other cycle.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            checkOutput("alt_valid", {31'd0, valid_if_id}, {31'd0, altExp[i]});
        end
        checkOutput("grant0", grantAddrs[0], 32'h0);
        checkOutput("grant1", grantAddrs[1], 32'h4);
        checkOutput("grant2", grantAddrs[2], 32'h8);
        checkOutput("instr8_loaded", {31'd0, valid_if_id && pc_if_id == 32'hC}, 32'd1);

        // Five stalled cycles: 0x8 stays put while 0xC is parked.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("hold_no_req", {31'd0, imem_req}, 32'd0);
        checkOutput("hold_keep_pc", pc_if_id, 32'hC);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("release_instr", instruction_if_id, memWord(32'hC));
        checkOutput("release_pc", pc_if_id, 32'h10);

        // Redirect while waiting; stale response arrives two cycles later.
        latLo = 3;
        latHi = 3;
        applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            if (valid_if_id) break;
        end
        checkOutput("redir_grant", lastGrantAddr, 32'h100);
        checkOutput("redir_pc", pc_if_id, 32'h104);
        checkOutput("redir_instr", instruction_if_id, memWord(32'h100));

        // Redirect landing on the same edge as rvalid, with ID stalled, and an unaligned target.
        latLo = 1;
        latHi = 1;
        for (int i = 0; i < 10; i++) begin
            if (outstanding && latLeft == 0) break;
            applyStimulus(1'b1, 1'b0, '0);
        end
        checkOutput("coinc_setup", {31'd0, outstanding && latLeft == 0}, 32'd1);
        applyStimulus(1'b1, 1'b1, 32'h203);
        gc0 = grantCount;
        for (int i = 0; i < 10; i++) begin
            if (grantCount > gc0) break;
            applyStimulus(1'b0, 1'b0, '0);
        end
        checkOutput("coinc_grant", lastGrantAddr, 32'h200);

        // PC wrap from the top of the address space.
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            if (valid_if_id) break;
        end
        checkOutput("wrap_instr", instruction_if_id, memWord(32'hFFFF_FFFC));
        checkOutput("wrap_pc", pc_if_id, 32'h0);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            if (valid_if_id) break;
        end
        checkOutput("wrap_next_pc", pc_if_id, 32'h4);

        // Asynchronous reset in the middle of WAIT.
        latLo = 2;
        latHi = 2;
        for (int i = 0; i < 10; i++) begin
            if (outstanding) break;
            applyStimulus(1'b0, 1'b0, '0);
        end
        checkOutput("wait_reached", {31'd0, outstanding}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("arst_addr", imem_addr, RESET_PC);
        checkOutput("arst_instr", instruction_if_id, NOP);
        checkOutput("arst_pc", pc_if_id, 32'd0);
        checkOutput("arst_valid", {31'd0, valid_if_id}, 32'd0);
        outstanding    = 1'b0;
        prevPending    = 1'b0;
        expPc          = RESET_PC;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        stall_id       = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_req", {31'd0, imem_req}, 32'd1);
        checkOutput("post_rst_addr", imem_addr, RESET_PC);

        // Randomized traffic against the stream model.
        gntPct = 70;
        latLo  = 1;
        latHi  = 3;
        d0     = delivered;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9) == 0) pcR = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                        pcR = $urandom & 32'h0000_0FFF;
            applyStimulus($urandom_range(99) < 30, $urandom_range(99) < 4, pcR);
        end
        checkOutput("progress", {31'd0, (delivered - d0) > 100}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction fetch stage; producer side of the IF/ID interface whose 32-bit instruction word the ID field splitter consumes. Holds the PC, issues word reads to instruction memory over a request/grant/response handshake, and loads the IF/ID register (instruction, PC+4, valid). Honours ID back-pressure (stall) and EX/ID redirects (branch/jump flush). At most one memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset (word aligned)
NOP_INSTR, 32'h0000_0000, instruction word driven when the IF/ID slot is empty or flushed

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch byte address, bits[1:0] always 0
imem_gnt  in  1  memory accepts request this cycle (imem_req && imem_gnt)
imem_rvalid  in  1  read data valid, earliest 1 cycle after grant
imem_rdata  in  32  instruction word
stall_id  in  1  ID cannot accept; hold IF/ID contents
redirect_valid  in  1  flush and redirect the PC
redirect_pc  in  32  new PC; bits[1:0] forced to 0
instruction_if_id  out  32  IF/ID instruction
pc_if_id  out  32  PC+4 of that instruction
valid_if_id  out  1  IF/ID slot holds a real instruction

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, state=FETCH, drop=0, hold buffer empty, imem_req=0, imem_addr=RESET_PC, instruction_if_id=NOP_INSTR, pc_if_id=0, valid_if_id=0. Outstanding responses are forgotten; imem must also be reset.
- FETCH: imem_req=1, imem_addr=pc_q. On grant -> WAIT.
- WAIT: imem_req=0. On rvalid: if drop=1 -> discard data, drop=0 -> FETCH. Otherwise, if slot free (valid_if_id=0 or stall_id=0), load instruction_if_id=rdata, pc_if_id=pc_q+4, valid_if_id=1, pc_q+=4 -> FETCH. If slot blocked, capture into hold buffer, pc_q+=4 -> HOLD.
- HOLD: imem_req=0. When stall_id=0, move buffer to IF/ID (valid=1) -> FETCH.
- IF/ID consumption: stall_id=0 with no new instruction loading -> valid_if_id=0, instruction_if_id=NOP_INSTR (bubble). stall_id=1 -> all three outputs hold.
- Best case throughput: one instruction per 2 cycles (FETCH, WAIT with 1-cycle memory).
- Redirect (highest priority, overrides stall): at the edge, valid_if_id=0, instruction_if_id=NOP_INSTR, pc_q={redirect_pc[31:2],2'b00}, hold buffer discarded.
  - FETCH without grant or HOLD -> FETCH.
  - FETCH with grant same cycle -> WAIT, drop=1.
  - WAIT without rvalid -> stay WAIT, drop=1.
  - WAIT with rvalid same cycle -> data discarded -> FETCH.
  - Redirect while drop=1 already: only pc_q updates.
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- imem_req never asserted in WAIT/HOLD; imem_addr stable while imem_req=1 and not granted.

Optional Feature:
IF_PERF_CNT_EN: adds output ports fetch_cnt[31:0] (instructions delivered to IF/ID, excluding dropped data) and stall_cnt[31:0] (cycles with valid_if_id=1 and stall_id=1). Both reset to 0, wrap at 2^32. Without the macro these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package if_pkg: fetch state enum (FETCH, WAIT, HOLD), NOP_INSTR default, word-align constant, INSTR_W=32.
- One natural sub-module: if_id_reg, the IF/ID pipeline register with load/hold/flush priority (flush > load > stall-hold > bubble).
- FSM, PC, and drop logic stay in the top module.

Test Plan:
- Reset then 1-cycle memory, gnt=1, rdata=addr: IF/ID shows (0x0, pc 0x4), then (0x4, pc 0x8), valid every other cycle; imem_addr 0,4,8.
- stall_id=1 for 5 cycles after instr@0x8 loads: IF/ID holds 0x8; instr@0xC sits in HOLD. On release, 0xC appears next edge with no loss or duplicate.
- Redirect to 0x100 in WAIT, rvalid 2 cycles later: stale data dropped, valid_if_id=0, next request is imem_addr=0x100, IF/ID shows pc_if_id=0x104.
- Redirect coincident with rvalid and with stall_id=1: slot flushed to NOP_INSTR/valid=0, data discarded, next imem_addr=redirect_pc.
- redirect_pc=0x203 -> imem_addr=0x200. PC at 0xFFFF_FFFC fetches then wraps to 0x0.
- Assert rst_n=0 mid-WAIT: outputs reach reset values asynchronously; first request after release is RESET_PC.
